// File: rtl/cyq_cmp_pkg.sv
// cyq_cmp_pkg
//   Shared constants for the cyq_cmp_pipe comparator family.
//   - Number-format encodings carried on the fmt port.
//   - Bit positions of the one-hot {gt,eq,lt} result vector.
package cyq_cmp_pkg;

    // Number formats. Any code not listed (2'd3) is treated as unsigned.
    localparam logic [1:0] FMT_SM = 2'd0;   // sign-magnitude
    localparam logic [1:0] FMT_TC = 2'd1;   // two's complement
    localparam logic [1:0] FMT_UN = 2'd2;   // unsigned

    // One-hot result bit indices.
    localparam int Q_GT = 2;
    localparam int Q_EQ = 1;
    localparam int Q_LT = 0;

    localparam int NUM_RES = 3;

endpackage

// File: rtl/cyq_fmt_conv.sv
// cyq_fmt_conv
//   Combinational operand normaliser: maps a WIDTH-bit operand in the
//   selected number format onto a common (WIDTH+1)-bit signed value so a
//   single signed comparison covers every format.
// Ports
//   value  in   WIDTH     raw operand
//   fmt    in   2         number format (FMT_SM / FMT_TC / FMT_UN, 3 = unsigned)
//   conv   out  WIDTH+1   signed normalised value
module cyq_fmt_conv
    import cyq_cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]        value,
    input  logic [1:0]              fmt,
    output logic signed [WIDTH:0]   conv
);

    // Magnitude field of a sign-magnitude operand, zero-extended.
    logic signed [WIDTH:0] sm_mag;

    always_comb begin
        sm_mag = signed'({2'b00, value[WIDTH-2:0]});
        conv   = signed'({1'b0, value});
        case (fmt)
            // Negating a zero magnitude yields zero, so -0 and +0 compare equal.
            FMT_SM:  conv = value[WIDTH-1] ? -sm_mag : sm_mag;
            FMT_TC:  conv = signed'({value[WIDTH-1], value});
            default: conv = signed'({1'b0, value});
        endcase
    end

endmodule

// File: rtl/cyq_cmp_pipe.sv
// cyq_cmp_pipe
//   Streaming magnitude comparator with a 2-stage valid/ready pipeline.
//   Stage 1 captures the operand pair already normalised by cyq_fmt_conv
//   (so fmt travels with its own pair); stage 2 captures the one-hot
//   compare result. Optional saturating result counters.
// Parameters
//   WIDTH  operand width (>=2)
//   CNT_W  statistics counter width (>=1)
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand handshake; a, b, fmt sampled on acceptance
//   out_valid/out_ready   result handshake; q = {gt,eq,lt} one-hot
//   stats_clr             synchronous counter clear (wins over a same-cycle count)
//   gt_cnt/eq_cnt/lt_cnt  saturating counts of delivered results
// Configuration
//   CYQ_CMP_STATS_EN  defined: counters present; undefined: counters read 0
//                     and stats_clr is ignored. Port list is unchanged.
module cyq_cmp_pipe
    import cyq_cmp_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       fmt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       q,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt
);

    logic signed [WIDTH:0] a_conv;
    logic signed [WIDTH:0] b_conv;

    logic                  s1_valid_reg;
    logic signed [WIDTH:0] s1_a_reg;
    logic signed [WIDTH:0] s1_b_reg;

    logic                  s2_valid_reg;
    logic [2:0]            q_reg;
    logic [2:0]            q_next;

    logic                  s2_advance;

    cyq_fmt_conv #(.WIDTH(WIDTH)) u_conv_a (
        .value (a),
        .fmt   (fmt),
        .conv  (a_conv)
    );

    cyq_fmt_conv #(.WIDTH(WIDTH)) u_conv_b (
        .value (b),
        .fmt   (fmt),
        .conv  (b_conv)
    );

    // A stage may load when it is empty or its contents leave this cycle.
    assign s2_advance = ~s2_valid_reg | out_ready;
    assign in_ready   = ~s1_valid_reg | s2_advance;

    always_comb begin
        q_next = 3'b000;
        if (s1_a_reg > s1_b_reg) begin
            q_next[Q_GT] = 1'b1;
        end else if (s1_a_reg == s1_b_reg) begin
            q_next[Q_EQ] = 1'b1;
        end else begin
            q_next[Q_LT] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s2_valid_reg <= 1'b0;
            q_reg        <= 3'b000;
        end else begin
            if (in_ready) begin
                s1_valid_reg <= in_valid;
                if (in_valid) begin
                    s1_a_reg <= a_conv;
                    s1_b_reg <= b_conv;
                end
            end
            if (s2_advance) begin
                s2_valid_reg <= s1_valid_reg;
                // q reads 000 whenever no result is held.
                q_reg        <= s1_valid_reg ? q_next : 3'b000;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign q         = q_reg;

`ifdef CYQ_CMP_STATS_EN
    logic                           out_fire;
    logic [NUM_RES-1:0][CNT_W-1:0]  cnt_all;

    assign out_fire = s2_valid_reg & out_ready;

    // One saturating counter per result bit, indexed like q.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RES; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                end else if (stats_clr) begin
                    cnt_reg <= '0;
                end else if (out_fire && q_reg[gi] && (cnt_reg != '1)) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_all[gi] = cnt_reg;
        end
    endgenerate

    assign gt_cnt = cnt_all[Q_GT];
    assign eq_cnt = cnt_all[Q_EQ];
    assign lt_cnt = cnt_all[Q_LT];
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;

    assign gt_cnt = '0;
    assign eq_cnt = '0;
    assign lt_cnt = '0;
`endif

endmodule

// File: tb/tb_cyq_cmp_pipe.sv
// tb_cyq_cmp_pipe
//   Directed bench for cyq_cmp_pipe: a WIDTH=4/CNT_W=2 instance for the
//   directed scenarios and a WIDTH=8 instance for a randomised sweep
//   against an independent reference model.
module tb_cyq_cmp_pipe;

`ifdef CYQ_CMP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=4 instance
    logic       in_valid, in_ready, out_valid, out_ready, stats_clr;
    logic [3:0] a, b;
    logic [1:0] fmt;
    logic [2:0] q;
    logic [1:0] gt_cnt, eq_cnt, lt_cnt;

    // WIDTH=8 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, stats_clr8;
    logic [7:0] a8, b8;
    logic [1:0] fmt8;
    logic [2:0] q8;
    logic [7:0] gt8, eq8, lt8;

    int checks   = 0;
    int failures = 0;

    cyq_cmp_pipe #(.WIDTH(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .fmt(fmt),
        .out_valid(out_valid), .out_ready(out_ready), .q(q),
        .stats_clr(stats_clr),
        .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
    );

    cyq_cmp_pipe #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .fmt(fmt8),
        .out_valid(out_valid8), .out_ready(out_ready8), .q(q8),
        .stats_clr(stats_clr8),
        .gt_cnt(gt8), .eq_cnt(eq8), .lt_cnt(lt8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [31:0] cexp(input int v);
        return STATS ? v : 0;
    endfunction

    // Reference: interpret an 8-bit operand per format as an integer.
    function automatic int to_int(input logic [7:0] v, input logic [1:0] f);
        case (f)
            2'd0:    return v[7] ? -int'(v[6:0]) : int'(v[6:0]);
            2'd1:    return int'($signed(v));
            default: return int'(v);
        endcase
    endfunction

    function automatic logic [2:0] ref_cmp(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] f);
        int vx, vy;
        vx = to_int(x, f);
        vy = to_int(y, f);
        if (vx > vy) return 3'b100;
        if (vx == vy) return 3'b010;
        return 3'b001;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] e8;
        int         n;
        int         stall;

        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; fmt = 0; out_ready = 1; stats_clr = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; fmt8 = 0; out_ready8 = 1; stats_clr8 = 0;

        // ---- reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 3'b000);
        chk("rst_gt_cnt", gt_cnt, 0);
        chk("rst_eq_cnt", eq_cnt, 0);
        chk("rst_lt_cnt", lt_cnt, 0);
        #2 rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_idle_out_valid", out_valid, 0);

        // ---- SM negative zero equals positive zero
        fmt = 2'd0; a = 4'b1000; b = 4'b0000; in_valid = 1;
        tick();
        in_valid = 0;
        chk("negz_latency1_out_valid", out_valid, 0);
        tick();
        chk("negz_out_valid", out_valid, 1);
        chk("negz_q", q, 3'b010);
        tick();
        chk("negz_drained", out_valid, 0);

        // ---- same bits, three formats back-to-back
        a = 4'b1011; b = 4'b0010; fmt = 2'd0; in_valid = 1;
        tick();
        fmt = 2'd1;
        tick();
        chk("fmt_sm_q", q, 3'b001);
        fmt = 2'd2;
        tick();
        in_valid = 0;
        chk("fmt_tc_q", q, 3'b001);
        tick();
        chk("fmt_un_q", q, 3'b100);
        tick();
        chk("fmt_drained", out_valid, 0);
        chk("cnt_after_fmt_lt", lt_cnt, cexp(2));
        chk("cnt_after_fmt_gt", gt_cnt, cexp(1));

        // ---- back-pressure: 3 pairs offered with out_ready low
        out_ready = 0; fmt = 2'd2;
        a = 4'd5; b = 4'd3; in_valid = 1;
        chk("bp_ready_p0", in_ready, 1);
        tick();
        a = 4'd3; b = 4'd3;
        chk("bp_ready_p1", in_ready, 1);
        tick();
        a = 4'd1; b = 4'd9;
        chk("bp_ready_p2_blocked", in_ready, 0);
        tick(); tick();
        chk("bp_hold_ready", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_q", q, 3'b100);
        out_ready = 1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        tick();
        in_valid = 0;
        chk("bp_res1_q", q, 3'b010);
        tick();
        chk("bp_res2_q", q, 3'b001);
        tick();
        chk("bp_drained", out_valid, 0);
        chk("bp_lt_cnt_sat", lt_cnt, cexp(3));
        chk("bp_eq_cnt", eq_cnt, cexp(2));

        // ---- reset mid-stream
        fmt = 2'd2; a = 4'd3; b = 4'd1; in_valid = 1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_out_valid", out_valid, 0);
        chk("rstm_q", q, 3'b000);
        chk("rstm_gt_cnt", gt_cnt, 0);
        chk("rstm_eq_cnt", eq_cnt, 0);
        chk("rstm_lt_cnt", lt_cnt, 0);
        in_valid = 0;
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rstm_idle_out_valid", out_valid, 0);
        end

        // ---- statistics saturation and clear priority
        stats_clr = 1;
        tick();
        stats_clr = 0;
        fmt = 2'd2; a = 4'd7; b = 4'd1; in_valid = 1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 4) in_valid = 0;
            chk("stats_gt_cnt", gt_cnt, cexp((i < 3) ? 0 : ((i - 2 > 3) ? 3 : i - 2)));
        end
        chk("stats_eq_cnt", eq_cnt, 0);
        chk("stats_lt_cnt", lt_cnt, 0);
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        chk("clr_pre_valid", out_valid, 1);
        stats_clr = 1;
        tick();
        stats_clr = 0;
        chk("clr_gt_cnt", gt_cnt, 0);
        chk("clr_eq_cnt", eq_cnt, 0);
        chk("clr_lt_cnt", lt_cnt, 0);
        chk("clr_out_valid", out_valid, 0);

        // ---- WIDTH=8 sweep with random stalls
        for (int i = 0; i < 40; i++) begin
            case (i)
                0: begin a8 = 8'h80; b8 = 8'h00; fmt8 = 2'd0; end
                1: begin a8 = 8'h81; b8 = 8'h7F; fmt8 = 2'd0; end
                2: begin a8 = 8'h80; b8 = 8'h7F; fmt8 = 2'd1; end
                3: begin a8 = 8'hFF; b8 = 8'h00; fmt8 = 2'd3; end
                default: begin
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    fmt8 = 2'($urandom_range(0, 3));
                end
            endcase
            e8 = ref_cmp(a8, b8, fmt8);
            stall = $urandom_range(0, 3);
            out_ready8 = (stall == 0);
            in_valid8 = 1;
            chk("sw_in_ready", in_ready8, 1);
            tick();
            in_valid8 = 0;
            n = 0;
            while (!out_valid8 && n < 10) begin
                tick();
                n++;
            end
            chk("sw_out_valid", out_valid8, 1);
            chk("sw_q", q8, e8);
            chk("sw_onehot", $onehot(q8), 1);
            for (int s = 0; s < stall; s++) begin
                tick();
                chk("sw_stall_q", q8, e8);
            end
            out_ready8 = 1;
            tick();
            chk("sw_drained", out_valid8, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
